// File: rtl/sdf_r2_delay_feedback_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// The feedback delay line lives in an external 1R1W synchronous-read memory.
// The operand for the next accepted sample is always prefetched one cycle ahead.
// A one-entry read buffer keeps that prefetched word safe while the stage stalls.
module sdf_r2_delay_feedback_stage #(
  parameter int DELAY  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int SCALE  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   out_idx,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [DATA_W-1:0] mem_R0_data,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [DATA_W-1:0] mem_W0_data
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DELAY - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              primed_q, primed_d;
  logic              rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              rd_buf_valid_q, rd_buf_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W:0]   out_idx_q, out_idx_d;

  logic [DATA_W-1:0] mem_q;
  logic              mem_avail;
  logic              accept;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] bf_sum;
  logic [DATA_W-1:0] bf_diff;

  // One signed component of the butterfly: 17-bit exact result, then halve or wrap.
  function automatic logic [HALF_W-1:0] bf_comp(input logic [HALF_W-1:0] a,
                                                input logic [HALF_W-1:0] b,
                                                input logic              sub);
    logic [HALF_W:0] r;
    r = sub ? ({a[HALF_W-1], a} - {b[HALF_W-1], b})
            : ({a[HALF_W-1], a} + {b[HALF_W-1], b});
    return (SCALE != 0) ? r[HALF_W:1] : r[HALF_W-1:0];
  endfunction

  // Operand selection, handshake and butterfly arithmetic.
  always_comb begin
    mem_q     = rd_pending_q ? mem_R0_data : rd_buf_q;
    mem_avail = rd_pending_q | rd_buf_valid_q;
    in_ready  = mem_avail & (~out_valid_q | out_ready);
    accept    = in_valid & in_ready;
    addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    bf_sum    = {bf_comp(mem_q[DATA_W-1:HALF_W], in_data[DATA_W-1:HALF_W], 1'b0),
                 bf_comp(mem_q[HALF_W-1:0],      in_data[HALF_W-1:0],      1'b0)};
    bf_diff   = {bf_comp(mem_q[DATA_W-1:HALF_W], in_data[DATA_W-1:HALF_W], 1'b1),
                 bf_comp(mem_q[HALF_W-1:0],      in_data[HALF_W-1:0],      1'b1)};
  end

  // Next-state logic: memory ports, read buffer, address/phase counter, output register.
  always_comb begin
    addr_d         = addr_q;
    phase_d        = phase_q;
    primed_d       = primed_q;
    rd_pending_d   = 1'b0;
    rd_buf_d       = rd_buf_q;
    rd_buf_valid_d = rd_buf_valid_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_idx_d      = out_idx_q;
    mem_R0_en      = 1'b0;
    mem_R0_addr    = addr_q;
    mem_W0_en      = 1'b0;
    mem_W0_addr    = addr_q;
    mem_W0_data    = in_data;

    if (rd_pending_q) begin
      rd_buf_d       = mem_R0_data;
      rd_buf_valid_d = 1'b1;
    end

    if (accept) begin
      rd_buf_valid_d = 1'b0;
      mem_R0_en      = 1'b1;
      mem_R0_addr    = addr_next;
      rd_pending_d   = 1'b1;
      mem_W0_en      = 1'b1;
      if (phase_q) begin
        mem_W0_data = bf_diff;
        out_data_d  = bf_sum;
      end else begin
        mem_W0_data = in_data;
        out_data_d  = mem_q;
      end
      out_idx_d   = {phase_q, addr_q};
      out_valid_d = phase_q | primed_q;
      addr_d      = addr_next;
      if (addr_q == LAST_ADDR) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          primed_d = 1'b1;
        end
      end
    end else begin
      if (!mem_avail) begin
        mem_R0_en    = 1'b1;
        mem_R0_addr  = addr_q;
        rd_pending_d = 1'b1;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q         <= '0;
      phase_q        <= 1'b0;
      primed_q       <= 1'b0;
      rd_pending_q   <= 1'b0;
      rd_buf_q       <= '0;
      rd_buf_valid_q <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= '0;
    end else begin
      addr_q         <= addr_d;
      phase_q        <= phase_d;
      primed_q       <= primed_d;
      rd_pending_q   <= rd_pending_d;
      rd_buf_q       <= rd_buf_d;
      rd_buf_valid_q <= rd_buf_valid_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_idx_q      <= out_idx_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sdf_r2_delay_feedback_stage.sv
// Bench for the SDF radix-2 stage: one scaled and one unscaled instance share a stream,
// each with its own delay memory; a sample-level model feeds per-instance scoreboards.
module tb_sdf_r2_delay_feedback_stage;

  localparam int DELAY = 128;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  idx;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [7:0]  out_idx0, out_idx1;
  logic [6:0]  r_addr0, r_addr1, w_addr0, w_addr1;
  logic        r_en0, r_en1, w_en0, w_en1;
  logic [31:0] r_data0, r_data1, w_data0, w_data1;

  logic [31:0] mem0 [DELAY];
  logic [31:0] mem1 [DELAY];

  int assert_count = 0;
  int fail_count   = 0;
  int cycle_cnt    = 0;
  int out_cnt1     = 0;
  bit rand_ready   = 0;
  bit cap_en       = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] cap0[$];
  logic [31:0] cap1[$];
  logic [7:0]  cap_idx1[$];

  logic [31:0] m_mem [2][DELAY];
  int          m_addr [2];
  bit          m_phase [2];
  bit          m_primed [2];

  sdf_r2_delay_feedback_stage #(.DELAY(DELAY), .ADDR_W(7), .DATA_W(32), .SCALE(0)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
    .mem_R0_addr(r_addr0), .mem_R0_en(r_en0), .mem_R0_data(r_data0),
    .mem_W0_addr(w_addr0), .mem_W0_en(w_en0), .mem_W0_data(w_data0));

  sdf_r2_delay_feedback_stage #(.DELAY(DELAY), .ADDR_W(7), .DATA_W(32), .SCALE(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
    .mem_R0_addr(r_addr1), .mem_R0_en(r_en1), .mem_R0_data(r_data1),
    .mem_W0_addr(w_addr1), .mem_W0_en(w_en1), .mem_W0_data(w_data1));

  always #5 clock = ~clock;

  // Synchronous-read delay memories, one per instance.
  always @(posedge clock) begin
    if (r_en0) r_data0 <= mem0[r_addr0];
    if (w_en0) mem0[w_addr0] <= w_data0;
    if (r_en1) r_data1 <= mem1[r_addr1];
    if (w_en1) mem1[w_addr1] <= w_data1;
    cycle_cnt++;
  end

  // Downstream acceptance: always ready, or a fair coin per cycle.
  always @(posedge clock) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One butterfly component computed with integer arithmetic.
  function automatic logic [15:0] comp(input logic [15:0] a, input logic [15:0] b,
                                       input bit sub, input bit scale);
    int s;
    logic [31:0] t;
    s = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
    if (scale) s = s >>> 1;
    t = s;
    return t[15:0];
  endfunction

  function automatic void modelStep(input int s, input logic [31:0] x);
    logic [31:0] a;
    exp_t e;
    bit v;
    a = m_mem[s][m_addr[s]];
    e.idx = {m_phase[s], 7'(m_addr[s])};
    if (!m_phase[s]) begin
      e.data = a;
      v = m_primed[s];
      m_mem[s][m_addr[s]] = x;
    end else begin
      e.data = {comp(a[31:16], x[31:16], 0, s == 1), comp(a[15:0], x[15:0], 0, s == 1)};
      m_mem[s][m_addr[s]] = {comp(a[31:16], x[31:16], 1, s == 1), comp(a[15:0], x[15:0], 1, s == 1)};
      v = 1;
    end
    if (v) begin
      if (s == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    if (m_addr[s] == DELAY - 1) begin
      m_addr[s] = 0;
      if (!m_phase[s]) m_primed[s] = 1;
      m_phase[s] = ~m_phase[s];
    end else begin
      m_addr[s]++;
    end
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < 2; s++) begin
      m_addr[s] = 0;
      m_phase[s] = 0;
      m_primed[s] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // Monitor: compare held outputs to the scoreboard head, pop on transfer, model accepts.
  always @(negedge clock) begin
    if (reset) begin
      if (out_valid0) begin
        if (q0.size() == 0) checkOutput("s0_unexpected_out", 32'd1, 32'd0);
        else begin
          checkOutput("s0_data", out_data0, q0[0].data);
          checkOutput("s0_idx", {24'd0, out_idx0}, {24'd0, q0[0].idx});
          if (out_ready) begin
            void'(q0.pop_front());
            if (cap_en) cap0.push_back(out_data0);
          end
        end
      end
      if (out_valid1) begin
        out_cnt1++;
        if (q1.size() == 0) checkOutput("s1_unexpected_out", 32'd1, 32'd0);
        else begin
          checkOutput("s1_data", out_data1, q1[0].data);
          checkOutput("s1_idx", {24'd0, out_idx1}, {24'd0, q1[0].idx});
          if (out_ready) begin
            void'(q1.pop_front());
            if (cap_en) begin
              cap1.push_back(out_data1);
              cap_idx1.push_back(out_idx1);
            end
          end
        end
      end
      if (in_valid && in_ready0) modelStep(0, in_data);
      if (in_valid && in_ready1) modelStep(1, in_data);
    end
  end

  // Present one sample and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] d);
    int waited = 0;
    in_data = d;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready1) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-cycle reset pulse with reset-value checks while it is held.
  task automatic pulseReset();
    in_valid = 1'b0;
    reset = 1'b0;
    modelReset();
    out_cnt1 = 0;
    @(posedge clock);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    checkOutput("rst_out_idx", {24'd0, out_idx1}, 32'd0);
    checkOutput("rst_out_data", out_data1, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready1}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int n;
    logic [15:0] r;
    modelReset();
    repeat (3) @(posedge clock);

    // Reset release: a single prefetch of address 0, then ready.
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("prefetch_en", {31'd0, r_en1}, 32'd1);
    checkOutput("prefetch_addr", {25'd0, r_addr1}, 32'd0);
    checkOutput("init_out_valid", {31'd0, out_valid1}, 32'd0);
    checkOutput("init_in_ready", {31'd0, in_ready1}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("ready_after_prefetch", {31'd0, in_ready1}, 32'd1);
    checkOutput("no_second_prefetch", {31'd0, r_en1}, 32'd0);
    checkOutput("idle_out_valid", {31'd0, out_valid1}, 32'd0);

    // Ramp x[k]=k, continuous, scaled instance checked against closed form.
    cap1.delete(); cap_idx1.delete(); cap_en = 1;
    c0 = cycle_cnt;
    for (int k = 0; k < 384; k++) applyStimulus({16'(k), 16'h0000});
    checkOutput("throughput", 32'(cycle_cnt - c0), 32'd384);
    idleCycles(3);
    cap_en = 0;
    checkOutput("ramp_count", 32'(cap1.size()), 32'd256);
    for (int i = 0; i < 256 && i < cap1.size(); i++) begin
      if (i < 128) begin
        r = 16'(64 + i);
        checkOutput("ramp_sum", cap1[i], {r, 16'h0000});
        checkOutput("ramp_sum_idx", {24'd0, cap_idx1[i]}, {24'd0, 1'b1, 7'(i)});
      end else begin
        checkOutput("ramp_diff", cap1[i], 32'hFFC0_0000);
        checkOutput("ramp_diff_idx", {24'd0, cap_idx1[i]}, {24'd0, 1'b0, 7'(i - 128)});
      end
    end

    // Overflow case: sum of full-scale operands wraps unscaled, halves scaled.
    pulseReset();
    cap0.delete(); cap1.delete(); cap_idx1.delete(); cap_en = 1;
    for (int k = 0; k < 256; k++) applyStimulus(32'h7FFF_8000);
    for (int k = 0; k < 128; k++) applyStimulus(32'h0000_0000);
    idleCycles(3);
    cap_en = 0;
    if (cap0.size() == 0 || cap1.size() == 0) checkOutput("wrap_count", 32'd0, 32'd1);
    else begin
      checkOutput("wrap_unscaled", cap0[0], 32'hFFFE_0000);
      checkOutput("wrap_scaled", cap1[0], 32'h7FFF_8000);
      checkOutput("wrap_diff_unscaled", cap0[128], 32'h0000_0000);
    end

    // Random data with a coin-flip downstream.
    rand_ready = 1;
    for (int k = 0; k < 1024; k++) applyStimulus($urandom);

    // Upstream gaps, always including one across the address wrap.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0 || m_addr[1] == 0) idleCycles($urandom_range(1, 3));
      applyStimulus($urandom);
    end

    // Reset in the middle of a butterfly block.
    n = 0;
    while (!(m_phase[1] == 1 && m_addr[1] == 40) && n < 1000) begin
      applyStimulus($urandom);
      n++;
    end
    checkOutput("reach_addr40", {31'd0, m_phase[1]}, 32'd1);
    pulseReset();
    rand_ready = 0;
    for (int k = 0; k < 128; k++) applyStimulus($urandom);
    idleCycles(3);
    checkOutput("post_reset_suppressed", 32'(out_cnt1), 32'd0);
    rand_ready = 1;
    for (int k = 0; k < 256; k++) applyStimulus($urandom);

    // Drain whatever is still expected.
    rand_ready = 0;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      idleCycles(1);
      n++;
    end
    checkOutput("drain_s0", 32'(q0.size()), 32'd0);
    checkOutput("drain_s1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sdf_r2_delay_feedback_stage.md
Name: sdf_r2_delay_feedback_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT pipeline.
- Owns the feedback delay line through an external 1R1W synchronous-read memory (128x32 delay macro wrapper, 7-bit address).
- Accepts one complex sample per cycle and emits butterfly sum/difference samples in natural SDF order to the downstream twiddle multiplier.
- Handles backpressure without losing prefetched memory data.

Parameters:
- DELAY, 128, delay-line depth (N/2 for this stage); must be >= 2.
- ADDR_W, 7, memory address width; 2^ADDR_W >= DELAY.
- DATA_W, 32, packed complex width: [31:16] real, [15:0] imag, both signed.
- SCALE, 1, 1 = sum/diff arithmetic right shift by 1 (floor); 0 = unscaled, wrap to 16 bits.

Ports:
- clock  in  1  stage clock; also drives both memory ports.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  32  input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage can accept this cycle.
- out_data  out  32  output sample.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_idx  out  ADDR_W+1  {phase, addr} of the accepted input that produced out_data (twiddle index).
- mem_R0_addr  out  ADDR_W  memory read address.
- mem_R0_en  out  1  memory read enable; data returns the next cycle.
- mem_R0_data  in  32  memory read data.
- mem_W0_addr  out  ADDR_W  memory write address.
- mem_W0_en  out  1  memory write enable.
- mem_W0_data  out  32  memory write data.

Behaviour:
- State and reset values:
  - addr (0..DELAY-1): 0.
  - phase: 0.
  - primed: 0.
  - rd_pending: 0.
  - rd_buf: 0.
  - rd_buf_valid: 0.
  - out_data: 0.
  - out_valid: 0.
  - out_idx: 0.
- Memory operand:
  - mem_q = rd_pending ? mem_R0_data : rd_buf.
  - mem_avail = rd_pending | rd_buf_valid.
  - When rd_pending, rd_buf <= mem_R0_data and rd_buf_valid <= 1. rd_buf_valid clears on accept.
- Handshake:
  - in_ready = mem_avail & (!out_valid | out_ready).
  - accept = in_valid & in_ready.
- Read issue:
  - On accept: R0_en=1, R0_addr=addr_next. Sets rd_pending for the next cycle.
  - When idle with !mem_avail and no read pending: R0_en=1, R0_addr=addr. This is the initial prefetch after reset.
  - Otherwise R0_en=0.
  - Read and write never target the same address in one cycle, because DELAY >= 2.
- Phase 0 (fill), on accept:
  - W0 writes mem[addr] <= in_data.
  - Output candidate = mem_q (difference stored by the previous block).
- Phase 1 (butterfly), on accept, with a = mem_q and b = in_data, per real/imag component:
  - Output = (a+b) computed 17-bit, then >>>1 if SCALE, else low 16 bits.
  - W0 writes mem[addr] <= (a-b), same rule.
- Counter: on accept, addr increments. At DELAY-1 it wraps to 0, phase toggles, and primed is set at the first 0->1 toggle.
- Output register:
  - On accept, out_data and out_idx load.
  - out_valid <= (phase==1) | primed. This suppresses the first DELAY garbage phase-0 outputs after reset.
  - Otherwise, out_valid clears when out_ready.
  - Latency: accept -> out_valid exactly 1 cycle.
  - out_data and out_idx hold while out_valid & !out_ready.
- Throughput: 1 sample/cycle sustained when in_valid=out_ready=1. Bubbles upstream or downstream do not lose or reorder memory data.
- Reset mid-operation: all state returns to reset values and memory contents are ignored. Phase-0 outputs are suppressed again until the first phase toggle.

Test Plan:
- Reset, then in_valid=0 -> one prefetch read: R0_en=1, R0_addr=0 in the cycle after reset release. out_valid stays 0. in_ready=1 two cycles after release.
- Stream x[k]=k (real=k, imag=0), SCALE=1, DELAY=128, continuous -> first 128 accepts give no out_valid. Accepts 128..255 output real=(k-128+k)>>1, i.e. k-64 (first =64). Next 128 accepts output real=(k-128-k)>>1, i.e. -64, for all samples.
- Same stream with SCALE=0, real=0x7FFF sum case -> output wraps to the low 16 bits. Stored diff matches 16-bit wrap.
- out_ready random 50% toggling over 1024 samples -> output sequence identical to the continuous run. No duplicates, no drops. out_data stable while stalled.
- in_valid gaps, including a gap straddling addr wrap 127->0 -> phase toggles only on accept. out_idx goes from {0,127} to {1,0} correctly.
- Assert reset for 1 cycle mid-phase-1 at addr=40 -> addr=0, phase=0, out_valid=0. Next 128 accepts produce no output.
